// File: rtl/alu_seq_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic/compare ops plus iterative
// unsigned multiply (shift-add) and divide (restoring), with valid/ready handshakes.
module alu_seq_unit #(
    parameter  int WIDTH = 64,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             div_by_zero,
    output logic             illegal_op
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_MULU = 4'b1001;
    localparam logic [3:0] OP_DIVU = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    state_e             state_q;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   acc_q;     // high product / partial remainder
    logic [WIDTH-1:0]   q_q;       // multiplier / quotient shift register
    logic [WIDTH-1:0]   b_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_hi_q;
    logic               carry_q;
    logic               overflow_q;
    logic               zero_q;
    logic               dbz_q;
    logic               illegal_q;

    // Single-cycle datapath, evaluated on the raw inputs at the accept edge.
    logic               is_sub;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum_full;
    logic               msb_cin;
    logic [WIDTH-1:0]   res_d;
    logic               carry_d;
    logic               overflow_d;
    logic               illegal_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        res_d      = '0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        illegal_d  = 1'b0;
        is_sub     = (op == OP_SUB);
        b_eff      = is_sub ? ~b : b;
        sum_full   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        msb_cin    = a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum_full[WIDTH-1];
        case (op)
            OP_AND:  res_d = a & b;
            OP_OR:   res_d = a | b;
            OP_NOR:  res_d = ~(a | b);
            OP_ADD, OP_SUB: begin
                res_d      = sum_full[WIDTH-1:0];
                carry_d    = sum_full[WIDTH];
                overflow_d = msb_cin ^ sum_full[WIDTH];
            end
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MULU, OP_DIVU: res_d = '0;
            default: illegal_d = 1'b1;
        endcase
    end

    // One multiply or divide iteration on the latched operands.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]   q_d;

    always_comb begin
        mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_q, q_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = ~div_diff[WIDTH];
        if (op_q == OP_MULU) begin
            acc_d = mul_sum[WIDTH:1];
            q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
        end else begin
            acc_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            q_d   = {q_q[WIDTH-2:0], div_ge};
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            acc_q       <= '0;
            q_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q <= op;
                        b_q  <= b;
                        if (op == OP_MULU || op == OP_DIVU) begin
                            acc_q   <= '0;
                            q_q     <= a;
                            cnt_q   <= CNT_W'(WIDTH);
                            state_q <= S_CALC;
                        end else begin
                            result_q    <= res_d;
                            result_hi_q <= '0;
                            carry_q     <= carry_d;
                            overflow_q  <= overflow_d;
                            zero_q      <= (res_d == '0);
                            dbz_q       <= 1'b0;
                            illegal_q   <= illegal_d;
                            state_q     <= S_DONE;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        // A zero divisor never borrows, so quotient saturates to all ones and remainder becomes a.
                        result_q    <= q_d;
                        result_hi_q <= acc_d;
                        carry_q     <= 1'b0;
                        overflow_q  <= 1'b0;
                        zero_q      <= (q_d == '0);
                        dbz_q       <= (op_q == OP_DIVU) && (b_q == '0);
                        illegal_q   <= 1'b0;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign result      = result_q;
    assign result_hi   = result_hi_q;
    assign carry_out   = carry_q;
    assign overflow    = overflow_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;
    assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: single-cycle ops, multiply/divide latency,
// divide-by-zero, illegal op, output hold under backpressure, and mid-op reset.
module tb_alu_seq_unit;

    localparam int W = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [W-1:0]  result_hi;
    logic          carry_out;
    logic          overflow;
    logic          zero;
    logic          div_by_zero;
    logic          illegal_op;

    int errors = 0;
    int checks = 0;

    alu_seq_unit #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .result_hi   (result_hi),
        .carry_out   (carry_out),
        .overflow    (overflow),
        .zero        (zero),
        .div_by_zero (div_by_zero),
        .illegal_op  (illegal_op)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one op, then scramble the inputs and wait (bounded) for out_valid.
    // lat counts rising edges from the accept edge up to the one raising out_valid.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output bit busy_ready);
        @(negedge clock);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        @(posedge clock);
        #1;
        in_valid   = 1'b0;
        op         = 4'b0010;
        a          = 64'hA5A5_5A5A_DEAD_BEEF;
        b          = 64'h0123_4567_89AB_CDEF;
        lat        = 1;
        busy_ready = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) busy_ready = 1'b1;
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic finish_op();
        @(posedge clock);
        #1;
    endtask

    int lat;
    bit busy_rdy;
    bit seen;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = '0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result",    result,    0);
        check("rst_result_hi", result_hi, 0);
        check("rst_flags", {carry_out, overflow, zero, div_by_zero, illegal_op}, 0);
        @(negedge clock);
        reset = 1'b0;

        run_op(4'b0010, 212, 32, lat, busy_rdy);
        check("add_lat",    lat,       1);
        check("add_res",    result,    244);
        check("add_hi",     result_hi, 0);
        check("add_flags",  {carry_out, overflow, zero, div_by_zero, illegal_op}, 0);
        check("done_in_ready", in_ready, 0);
        finish_op();
        check("idle_out_valid", out_valid, 0);
        check("idle_in_ready",  in_ready,  1);

        run_op(4'b0110, 4192, 190, lat, busy_rdy);
        check("sub_res",   result,    4002);
        check("sub_carry", carry_out, 1);
        check("sub_ovf",   overflow,  0);
        finish_op();

        run_op(4'b0111, 632, 4321, lat, busy_rdy);
        check("slt_pos_res",   result,    1);
        check("slt_pos_carry", carry_out, 0);
        finish_op();

        run_op(4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 1, lat, busy_rdy);
        check("slt_neg_res", result, 1);
        finish_op();

        run_op(4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 1, lat, busy_rdy);
        check("sltu_res",  result, 0);
        check("sltu_zero", zero,   1);
        finish_op();

        run_op(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 1, lat, busy_rdy);
        check("addov_res",   result,    64'h8000_0000_0000_0000);
        check("addov_ovf",   overflow,  1);
        check("addov_carry", carry_out, 0);
        finish_op();

        run_op(4'b0110, 5, 5, lat, busy_rdy);
        check("subz_res",   result,    0);
        check("subz_zero",  zero,      1);
        check("subz_carry", carry_out, 1);
        check("subz_ovf",   overflow,  0);
        finish_op();

        run_op(4'b0000, 64'hF0F0, 64'hFF00, lat, busy_rdy);
        check("and_res", result, 64'hF000);
        finish_op();
        run_op(4'b0001, 64'hF0F0, 64'hFF00, lat, busy_rdy);
        check("or_res", result, 64'hFFF0);
        finish_op();
        run_op(4'b1100, 64'hF0F0, 64'hFF00, lat, busy_rdy);
        check("nor_res", result, 64'hFFFF_FFFF_FFFF_000F);
        finish_op();

        run_op(4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 2, lat, busy_rdy);
        check("mul_lat",      lat,       65);
        check("mul_busy_rdy", busy_rdy,  0);
        check("mul_lo",       result,    64'hFFFF_FFFF_FFFF_FFFE);
        check("mul_hi",       result_hi, 1);
        check("mul_flags", {carry_out, overflow, zero, div_by_zero, illegal_op}, 0);
        finish_op();

        run_op(4'b1001, 64'h1_0000_0000, 64'h1_0000_0000, lat, busy_rdy);
        check("mul2_lo",   result,    0);
        check("mul2_hi",   result_hi, 1);
        check("mul2_zero", zero,      1);
        finish_op();

        run_op(4'b1010, 4321, 32, lat, busy_rdy);
        check("div_lat", lat,         65);
        check("div_q",   result,      135);
        check("div_r",   result_hi,   1);
        check("div_dbz", div_by_zero, 0);
        finish_op();

        run_op(4'b1010, 212, 0, lat, busy_rdy);
        check("dbz_q",    result,      64'hFFFF_FFFF_FFFF_FFFF);
        check("dbz_r",    result_hi,   212);
        check("dbz_flag", div_by_zero, 1);
        finish_op();

        run_op(4'b1111, 77, 99, lat, busy_rdy);
        check("ill_lat",  lat,        1);
        check("ill_flag", illegal_op, 1);
        check("ill_res",  result,     0);
        finish_op();

        // Backpressure: outputs must hold while out_ready is low.
        out_ready = 1'b0;
        run_op(4'b0010, 3, 4, lat, busy_rdy);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready,  0);
            check("hold_res",   result,    7);
        end
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("release_valid", out_valid, 0);
        check("release_ready", in_ready,  1);

        // Reset in the middle of a multiply discards it.
        @(negedge clock);
        in_valid = 1'b1;
        op       = 4'b1001;
        a        = 64'hFFFF_FFFF_FFFF_FFFF;
        b        = 3;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mrst_valid", out_valid, 0);
        check("mrst_ready", in_ready,  1);
        check("mrst_res",   result,    0);
        check("mrst_hi",    result_hi, 0);
        @(negedge clock);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (80) begin
            @(posedge clock);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("mrst_no_output", seen, 0);

        run_op(4'b0010, 1, 1, lat, busy_rdy);
        check("post_rst_lat", lat,    1);
        check("post_rst_add", result, 2);
        finish_op();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
